// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART transmitter
// between N_REQ byte streams, with a hold timeout for stalled owners.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned HOLD_TIMEOUT = 1023,
    parameter int unsigned TO_W         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_wr,
    input  logic                    tx_busy,
    output logic                    timeout_err
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_BSY,
        DRAIN
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic              last_q;
    logic [TO_W-1:0]   to_cnt;

    logic              any_valid;
    logic              found_hi;
    logic              found_lo;
    logic [PTR_W-1:0]  hi_idx;
    logic [PTR_W-1:0]  lo_idx;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;

    // Round-robin pick: first valid at/after rr_ptr, else first valid from 0.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found_hi && req_valid[i] && (i >= 32'(rr_ptr))) begin
                found_hi = 1'b1;
                hi_idx   = PTR_W'(i);
            end
            if (!found_lo && req_valid[i]) begin
                found_lo = 1'b1;
                lo_idx   = PTR_W'(i);
            end
        end
        pick_idx  = found_hi ? hi_idx : lo_idx;
        any_valid = |req_valid;
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(owner) == i) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
        next_ptr = (32'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            last_q      <= 1'b0;
            to_cnt      <= '0;
            grant       <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_wr       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant  <= N_REQ'(1) << pick_idx;
                        owner  <= pick_idx;
                        to_cnt <= '0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // A byte arriving on the expiry cycle takes priority over the timeout.
                    if (own_valid && !tx_busy) begin
                        req_ready <= grant;
                        tx_wr     <= 1'b1;
                        tx_data   <= own_data;
                        last_q    <= own_last;
                        to_cnt    <= '0;
                        state     <= WAIT_BSY;
                    end else if (!own_valid) begin
                        if (to_cnt == TO_W'(HOLD_TIMEOUT - 1)) begin
                            to_cnt      <= TO_W'(HOLD_TIMEOUT);
                            timeout_err <= 1'b1;
                            grant       <= '0;
                            rr_ptr      <= next_ptr;
                            state       <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                WAIT_BSY: begin
                    tx_wr     <= 1'b0;
                    req_ready <= '0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant  <= '0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: message-level round-robin model,
// behavioural UART busy model, randomized batches plus directed scenarios.
module tb_uart_tx_arbiter;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int HT   = 1023;
    localparam int MAXB = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic [DW-1:0]   tx_data;
    logic            tx_wr;
    logic            tx_busy = 1'b0;
    logic            timeout_err;

    uart_tx_arbiter #(
        .N_REQ(N),
        .DATA_W(DW),
        .HOLD_TIMEOUT(HT),
        .TO_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_data(tx_data),
        .tx_wr(tx_wr),
        .tx_busy(tx_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_to;
        int         req;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // per-requester byte streams presented by the requester drivers
    logic [7:0] dbuf[N][MAXB];
    bit         lbuf[N][MAXB];
    int         hd[N];
    int         tl[N];
    bit         pop_pend[N];

    // batch description: up to 4 messages of up to 4 bytes per requester
    int         mcnt[N];
    int         mlen[N][4];
    logic [7:0] mbyte[N][4][4];
    int         mstall[N][4];

    int model_ptr  = 0;
    int busy_fixed = 0;
    int wr_seen    = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -9;
    endfunction

    function automatic bit drained();
        for (int i = 0; i < N; i++)
            if (hd[i] != tl[i] || pop_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_batch();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0;
            for (int m = 0; m < 4; m++) begin
                mlen[i][m]   = 1;
                mstall[i][m] = -1;
                for (int b = 0; b < 4; b++) mbyte[i][m][b] = 8'h00;
            end
        end
    endtask

    // Expected byte order: each arbitration hands one whole message to the
    // first requester with pending messages at/after the pointer.
    task automatic launch_batch();
        int next_msg[N];
        int prev_kind;  // 0 none, 1 mid-message byte, 2 last byte, 3 timeout
        int g;
        int m;
        exp_t e;
        @(posedge clk);
        #1;
        prev_kind = 0;
        for (int i = 0; i < N; i++) next_msg[i] = 0;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && next_msg[(model_ptr + k) % N] < mcnt[(model_ptr + k) % N])
                    g = (model_ptr + k) % N;
            if (g < 0) break;
            m = next_msg[g];
            next_msg[g]++;
            for (int b = 0; b < mlen[g][m]; b++) begin
                if (mstall[g][m] >= 0 && b > mstall[g][m]) break;
                e.is_to = 1'b0;
                e.req   = g;
                e.data  = mbyte[g][m][b];
                e.gap   = (prev_kind == 0) ? 0 : (prev_kind == 2) ? 3 : 2;
                sb.push_back(e);
                prev_kind = (b == mlen[g][m] - 1) ? 2 : 1;
            end
            if (mstall[g][m] >= 0) begin
                e.is_to = 1'b1;
                e.req   = g;
                e.data  = 8'h00;
                e.gap   = HT + 1;
                sb.push_back(e);
                prev_kind   = 3;
                next_msg[g] = mcnt[g];
            end
            model_ptr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            for (int mm = 0; mm < mcnt[i]; mm++) begin
                for (int b = 0; b < mlen[i][mm]; b++) begin
                    if (mstall[i][mm] >= 0 && b > mstall[i][mm]) break;
                    dbuf[i][tl[i]] = mbyte[i][mm][b];
                    lbuf[i][tl[i]] = (b == mlen[i][mm] - 1);
                    tl[i]++;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            done = (sb.size() == 0) && (grant == '0) && !tx_busy && drained();
        end
        check_eq("batch_done", int'(done), 1);
    endtask

    task automatic random_batch(input bit with_stall);
        int r;
        clear_batch();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = $urandom_range(0, 2);
            for (int m = 0; m < 4; m++) begin
                mlen[i][m] = $urandom_range(1, 4);
                for (int b = 0; b < 4; b++) mbyte[i][m][b] = 8'($urandom);
            end
        end
        if (mcnt[0] + mcnt[1] + mcnt[2] == 0) mcnt[0] = 1;
        if (with_stall) begin
            r = $urandom_range(0, N - 1);
            if (mcnt[r] == 0) mcnt[r] = 1;
            if (mlen[r][mcnt[r]-1] < 2) mlen[r][mcnt[r]-1] = 2;
            mstall[r][mcnt[r]-1] = $urandom_range(0, mlen[r][mcnt[r]-1] - 2);
        end
        launch_batch();
        wait_idle();
    endtask

    // Requester drivers: hold valid while bytes remain, advance one cycle after ready.
    initial begin
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            pop_pend[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    pop_pend[i]  = 1'b0;
                    req_valid[i] = 1'b0;
                end else begin
                    if (pop_pend[i]) begin
                        pop_pend[i] = 1'b0;
                        if (hd[i] < tl[i]) hd[i]++;
                    end
                    if (req_ready[i] && req_valid[i]) pop_pend[i] = 1'b1;
                    req_valid[i] = (hd[i] < tl[i]);
                    if (hd[i] < tl[i]) begin
                        req_data[i*DW +: DW] = dbuf[i][hd[i]];
                        req_last[i]          = lbuf[i][hd[i]];
                    end else begin
                        req_data[i*DW +: DW] = '0;
                        req_last[i]          = 1'b0;
                    end
                end
            end
        end
    end

    // UART core: busy from the cycle after tx_wr for a per-byte frame length.
    initial begin
        int cnt;
        bit pend;
        cnt  = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_busy = 1'b0;
                cnt     = 0;
                pend    = 1'b0;
            end else begin
                if (pend) begin
                    pend    = 1'b0;
                    tx_busy = 1'b1;
                    cnt     = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 12));
                end else if (tx_busy) begin
                    cnt--;
                    if (cnt == 0) tx_busy = 1'b0;
                end
                if (tx_wr) pend = 1'b1;
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pops on tx_wr / timeout_err.
    initial begin
        int   n;
        int   ref_n;
        bit   prev_busy;
        int   prev_g;
        exp_t e;
        n = 0;
        ref_n = 0;
        prev_busy = 1'b0;
        prev_g = -9;
        forever begin
            @(negedge clk);
            n++;
            if (rst) begin
                prev_busy = 1'b0;
                prev_g    = -9;
            end else begin
                tests++;
                if (!($onehot0(grant) && $onehot0(req_ready) && ((req_ready & ~grant) == '0)
                      && !(tx_wr && tx_busy))) begin
                    fails++;
                    $display("FAIL invariant: grant=%b req_ready=%b tx_wr=%b tx_busy=%b",
                             grant, req_ready, tx_wr, tx_busy);
                end
                if (prev_busy && !tx_busy) ref_n = n;
                prev_busy = tx_busy;
                if (tx_wr) begin
                    wr_seen++;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: unexpected tx_wr data=%02h grant=%b", tx_data, grant);
                    end else begin
                        e = sb.pop_front();
                        check_eq("tx_req", idx_of(grant), e.is_to ? -1 : e.req);
                        check_eq("tx_data", int'(tx_data), int'(e.data));
                        if (!e.is_to) check_eq("req_ready", int'(req_ready), 1 << e.req);
                        if (e.gap != 0) check_eq("wr_gap", n - ref_n, e.gap);
                    end
                end
                if (timeout_err) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_underflow: unexpected timeout_err prev_grant=%0d", prev_g);
                    end else begin
                        e = sb.pop_front();
                        check_eq("to_req", prev_g, e.is_to ? e.req : -1);
                        check_eq("grant_after_to", int'(grant), 0);
                        if (e.gap != 0) check_eq("to_gap", n - ref_n, e.gap);
                    end
                    ref_n = n;
                end
                prev_g = idx_of(grant);
            end
        end
    end

    initial begin
        int base;
        int c;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_req_ready", int'(req_ready), 0);
        check_eq("rst_tx_wr", int'(tx_wr), 0);
        check_eq("rst_tx_data", int'(tx_data), 0);
        check_eq("rst_timeout_err", int'(timeout_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // contention: two 3-byte messages, req0 first
        busy_fixed = 10;
        clear_batch();
        mcnt[0] = 1; mlen[0][0] = 3;
        mbyte[0][0][0] = 8'h10; mbyte[0][0][1] = 8'h11; mbyte[0][0][2] = 8'h12;
        mcnt[1] = 1; mlen[1][0] = 3;
        mbyte[1][0][0] = 8'h20; mbyte[1][0][1] = 8'h21; mbyte[1][0][2] = 8'h22;
        launch_batch();
        wait_idle();

        // single requester "Hi"
        clear_batch();
        mcnt[0] = 1; mlen[0][0] = 2;
        mbyte[0][0][0] = 8'h48; mbyte[0][0][1] = 8'h69;
        launch_batch();
        wait_idle();

        // fairness and pointer wrap: everyone sends two 1-byte messages
        busy_fixed = 0;
        clear_batch();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 2;
            mlen[i][0] = 1; mbyte[i][0][0] = 8'(8'h30 + i);
            mlen[i][1] = 1; mbyte[i][1][0] = 8'(8'h40 + i);
        end
        launch_batch();
        wait_idle();

        // timeout: req1 stalls after 0xAA, pending req0 goes next
        busy_fixed = 10;
        clear_batch();
        mcnt[1] = 1; mlen[1][0] = 2; mstall[1][0] = 0;
        mbyte[1][0][0] = 8'hAA; mbyte[1][0][1] = 8'hBB;
        mcnt[0] = 1; mlen[0][0] = 1; mbyte[0][0][0] = 8'h5A;
        launch_batch();
        wait_idle();

        // long busy: next byte must wait for busy to fall
        busy_fixed = 50;
        clear_batch();
        mcnt[2] = 1; mlen[2][0] = 3;
        mbyte[2][0][0] = 8'hC0; mbyte[2][0][1] = 8'hC1; mbyte[2][0][2] = 8'hC2;
        launch_batch();
        wait_idle();

        busy_fixed = 0;
        for (int k = 0; k < 30; k++) random_batch(k == 9 || k == 21);

        // leave the pointer at 1, then reset in the middle of req1's message
        busy_fixed = 10;
        clear_batch();
        mcnt[0] = 1; mlen[0][0] = 1; mbyte[0][0][0] = 8'h77;
        launch_batch();
        wait_idle();
        clear_batch();
        mcnt[1] = 1; mlen[1][0] = 4;
        mbyte[1][0][0] = 8'hD0; mbyte[1][0][1] = 8'hD1;
        mbyte[1][0][2] = 8'hD2; mbyte[1][0][3] = 8'hD3;
        base = wr_seen;
        launch_batch();
        c = 0;
        while (wr_seen < base + 2 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("reach_byte2", int'(wr_seen >= base + 2), 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_grant", int'(grant), 0);
        check_eq("midrst_req_ready", int'(req_ready), 0);
        check_eq("midrst_tx_wr", int'(tx_wr), 0);
        check_eq("midrst_tx_data", int'(tx_data), 0);
        sb.delete();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        model_ptr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // after reset the search restarts at requester 0
        busy_fixed = 0;
        clear_batch();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 1; mlen[i][0] = 2;
            mbyte[i][0][0] = 8'(8'hE0 + i); mbyte[i][0][1] = 8'(8'hF0 + i);
        end
        launch_batch();
        wait_idle();

        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single SoC UART transmitter between N_REQ byte-stream requesters, e.g. the LM32 console path and a hardware status/debug streamer.
- Arbitration is round-robin and message-granular. A grant is held until the requester sends a byte flagged last, so messages never interleave on uart_txd.
- Sits between the requesters and the UART core's transmit strobe/busy interface.
- A hold timeout frees the UART if a granted requester stalls mid-message.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width sent to the UART core.
- HOLD_TIMEOUT, 1023, consecutive idle cycles a granted requester may leave req_valid low before its grant is revoked.
- TO_W, 10, timeout counter width; must satisfy 2^TO_W > HOLD_TIMEOUT.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, N_REQ, per-requester byte valid.
- req_data, input, N_REQ*DATA_W, per-requester byte; requester i uses bits [i*DATA_W +: DATA_W].
- req_last, input, N_REQ, byte is the final byte of the requester's message.
- req_ready, output, N_REQ, one-hot accept strobe; the byte transfers when req_valid[i] & req_ready[i].
- grant, output, N_REQ, one-hot current owner; all zero when idle.
- tx_data, output, DATA_W, byte to the UART core.
- tx_wr, output, 1, single-cycle write strobe to the UART core.
- tx_busy, input, 1, UART core busy. Contract: rises the cycle after tx_wr and stays high until the stop bit completes.
- timeout_err, output, 1, one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; grant, req_ready, tx_wr, timeout_err = 0; tx_data=0; timeout counter=0. Reset asserted mid-byte drops the grant immediately; the UART core is reset by the same rst.
- All outputs are registered.
- IDLE:
  - If any req_valid is set, grant the first requester at or after rr_ptr, searching upward modulo N_REQ.
  - Next state GRANT. grant is visible the following cycle.
- GRANT (owner g):
  - If req_valid[g]=1 and tx_busy=0: in the same registered update, set req_ready[g]=1, tx_wr=1, tx_data=req_data[g]; latch last_q=req_last[g]; clear the timeout counter. Next state WAIT_BSY.
  - If req_valid[g]=0: increment the timeout counter. When it reaches HOLD_TIMEOUT, pulse timeout_err, clear grant, set rr_ptr=(g+1) mod N_REQ, and go to IDLE.
  - req_valid from non-owners is ignored; their req_ready stays 0.
- WAIT_BSY: exactly one cycle; tx_wr and req_ready return to 0. Next state DRAIN.
- DRAIN:
  - Stay while tx_busy=1.
  - On tx_busy=0: if last_q=1, clear grant, set rr_ptr=(g+1) mod N_REQ, go to IDLE. Otherwise return to GRANT.
- Throughput:
  - Gaps per byte: one byte per UART frame plus 2 cycles between frames (the DRAIN→GRANT and GRANT→tx_wr registered steps).
  - Gaps at message boundaries: 3 cycles between the last byte's busy falling and the next owner's tx_wr (IDLE, GRANT, WAIT_BSY pipeline).
- Guarantees:
  - tx_wr never asserts while tx_busy=1.
  - grant and req_ready are always one-hot or zero.
  - req_ready[i] implies grant[i].
- Simultaneous events:
  - Several requesters valid in IDLE: the rr_ptr search decides.
  - A timeout expiry and req_valid[g] rising in the same cycle: the byte wins; no timeout.
- Wrap-around: rr_ptr increments modulo N_REQ (N_REQ-1 → 0).
- The timeout counter saturates at HOLD_TIMEOUT and is cleared on every new grant.

Test Plan:
- Single requester: req0 sends 0x48 (last=0) then 0x69 (last=1) with tx_busy modelled at 10 cycles/byte → two tx_wr pulses, tx_data 0x48 then 0x69; grant=01 throughout; grant=00 after the second busy falls.
- Contention: req0 and req1 both valid from reset release, each with a 3-byte message → all req0 bytes first (rr_ptr=0), then req1's three bytes; no interleaving; rr_ptr ends at 0.
- Fairness/wrap: N_REQ=3, all three requesters continuously valid with 1-byte messages → grant sequence 001,010,100,001; at most one req_ready per cycle.
- Timeout: req1 granted, sends 0xAA (last=0), then drops valid → timeout_err pulses HOLD_TIMEOUT (1023) idle cycles after returning to GRANT; grant clears; a pending req0 is granted next.
- Busy respect: hold tx_busy high for 50 cycles after tx_wr → no second tx_wr until 2 cycles after tx_busy falls.
- Reset mid-message: assert rst during DRAIN of byte 2 of 4 → grant, tx_wr, req_ready go 0 immediately; after release, arbitration restarts with rr_ptr=0.
